// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit bridging the MEM stage to a single-outstanding word bus
module lsu #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        memwrite,
  input  logic        memtoreg,
  input  logic [1:0]  swhb,
  input  logic [1:0]  lwhb,
  input  logic        lunsigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [4:0]  rd,
  output logic        stall,
  output logic [31:0] ldata,
  output logic        ldata_valid,
  output logic [4:0]  ld_rd,
  output logic        misalign,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic {IDLE, BUSY} state_t;

  // Last BUSY cycle index before the access is abandoned.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q;

  // Captured per-access context used when the read data returns.
  logic [4:0]  rd_q;
  logic [1:0]  lwhb_q;
  logic        lunsigned_q;
  logic [1:0]  off_q;

  logic        is_store, is_load, is_access;
  logic        sz_word, sz_half, sz_byte;
  logic        mis;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;

  logic        stall_c, misalign_c, err_c, start, done;
  logic [31:0] ext_data;

  // Request decode: a store wins over a load when both flags are set.
  always_comb begin
    is_store  = req_valid & memwrite & (swhb != 2'b00);
    is_load   = req_valid & memtoreg & ~memwrite;
    is_access = is_store | is_load;
    sz_word   = 1'b0;
    sz_half   = 1'b0;
    sz_byte   = 1'b0;
    if (is_store) begin
      sz_word = (swhb == 2'b01);
      sz_half = (swhb == 2'b10);
      sz_byte = (swhb == 2'b11);
    end else begin
      sz_half = (lwhb == 2'b01);
      sz_byte = (lwhb == 2'b10);
      sz_word = ~sz_half & ~sz_byte;
    end
    mis = is_access & ((sz_half & addr[0]) | (sz_word & (addr[1:0] != 2'b00)));
  end

  // Byte enables and lane-replicated write data for the bus.
  always_comb begin
    be_next    = 4'b1111;
    wdata_next = wdata;
    if (is_store) begin
      if (sz_byte) begin
        be_next    = 4'b0001 << addr[1:0];
        wdata_next = {4{wdata[7:0]}};
      end else if (sz_half) begin
        be_next    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{wdata[15:0]}};
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and per-cycle control strobes.
  always_comb begin
    state_d    = state_q;
    stall_c    = 1'b0;
    misalign_c = 1'b0;
    err_c      = 1'b0;
    start      = 1'b0;
    done       = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_access) begin
          if (mis) begin
            misalign_c = 1'b1;
          end else begin
            stall_c = 1'b1;
            start   = 1'b1;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (bus_ack) begin
          done    = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == TO_LAST) begin
          err_c   = 1'b1;
          state_d = IDLE;
        end else begin
          stall_c = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes are forced low while reset is held, even with a request present.
  assign stall    = stall_c & reset;
  assign misalign = misalign_c & reset;
  assign bus_err  = err_c & reset;

  // Wait counter: cleared on entry to BUSY, counts cycles without ack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= 16'd0;
    end else if (start || done || err_c) begin
      cnt_q <= 16'd0;
    end else if (state_q == BUSY) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  // Bus request and access context; held stable for the whole BUSY phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= 32'd0;
      bus_wdata   <= 32'd0;
      bus_be      <= 4'd0;
      rd_q        <= 5'd0;
      lwhb_q      <= 2'd0;
      lunsigned_q <= 1'b0;
      off_q       <= 2'd0;
    end else if (start) begin
      bus_req     <= 1'b1;
      bus_we      <= is_store;
      bus_addr    <= {addr[31:2], 2'b00};
      bus_wdata   <= wdata_next;
      bus_be      <= be_next;
      rd_q        <= rd;
      lwhb_q      <= lwhb;
      lunsigned_q <= lunsigned;
      off_q       <= addr[1:0];
    end else if (done || err_c) begin
      bus_req <= 1'b0;
    end
  end

  // Lane select and sign/zero extension of the returned read data.
  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    b = bus_rdata[8*off_q +: 8];
    h = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (lwhb_q)
      2'b01:   ext_data = lunsigned_q ? {16'd0, h} : {{16{h[15]}}, h};
      2'b10:   ext_data = lunsigned_q ? {24'd0, b} : {{24{b[7]}}, b};
      default: ext_data = bus_rdata;
    endcase
  end

  // Load writeback register; ldata holds until the next completed load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ldata       <= 32'd0;
      ld_rd       <= 5'd0;
      ldata_valid <= 1'b0;
    end else begin
      ldata_valid <= done & ~bus_we;
      if (done && !bus_we) begin
        ldata <= ext_data;
        ld_rd <= rd_q;
      end
    end
  end

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - directed self-checking bench for lsu
module tb_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, memwrite, memtoreg, lunsigned;
  logic [1:0]  swhb, lwhb;
  logic [31:0] addr, wdata;
  logic [4:0]  rd;
  logic        stall, ldata_valid, misalign, bus_err, bus_req, bus_we;
  logic [31:0] ldata, bus_addr, bus_wdata;
  logic [4:0]  ld_rd;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int n_chk  = 0;
  int n_pass = 0;

  lsu #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .memwrite(memwrite),
    .memtoreg(memtoreg), .swhb(swhb), .lwhb(lwhb), .lunsigned(lunsigned),
    .addr(addr), .wdata(wdata), .rd(rd), .stall(stall), .ldata(ldata),
    .ldata_valid(ldata_valid), .ld_rd(ld_rd), .misalign(misalign),
    .bus_err(bus_err), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Advance to 2ns after the next rising edge; inputs are driven here.
  task automatic cyc;
    @(posedge clk);
    #2;
  endtask

  task automatic no_req;
    req_valid = 0; memwrite = 0; memtoreg = 0; swhb = 2'b00; lwhb = 2'b00;
    lunsigned = 0; addr = 0; wdata = 0; rd = 0;
  endtask

  task automatic load(input logic [31:0] a, input logic [1:0] sz, input logic u, input logic [4:0] r);
    req_valid = 1; memtoreg = 1; memwrite = 0; swhb = 2'b00;
    lwhb = sz; lunsigned = u; addr = a; rd = r;
  endtask

  task automatic store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    req_valid = 1; memwrite = 1; memtoreg = 0; swhb = sz; lwhb = 2'b00;
    addr = a; wdata = d; rd = 0;
  endtask

  logic [3:0] sb_be [4];

  initial begin
    sb_be[0] = 4'b0001; sb_be[1] = 4'b0010; sb_be[2] = 4'b0100; sb_be[3] = 4'b1000;
    reset = 0; bus_ack = 0; bus_rdata = 0;
    no_req();

    // Reset state, with a request present to confirm stall is suppressed
    cyc();
    load(32'h100, 2'b00, 0, 5'd3);
    #2;
    check("rst_stall", stall, 0);
    check("rst_req", bus_req, 0);
    check("rst_addr", bus_addr, 0);
    check("rst_be", bus_be, 0);
    check("rst_ldata", ldata, 0);
    check("rst_ldv", ldata_valid, 0);
    cyc();
    no_req(); reset = 1;

    // lb 0x103 signed, ack after 2 BUSY cycles
    cyc();
    load(32'h103, 2'b10, 0, 5'd5);
    #2;
    check("lb_stall0", stall, 1);
    check("lb_req0", bus_req, 0);
    cyc(); #2;
    check("lb_req1", bus_req, 1);
    check("lb_addr", bus_addr, 32'h100);
    check("lb_be", bus_be, 4'b1111);
    check("lb_we", bus_we, 0);
    check("lb_stall1", stall, 1);
    cyc(); #2;
    check("lb_stall2", stall, 1);
    cyc();
    bus_ack = 1; bus_rdata = 32'h80112233;
    #2;
    check("lb_stall3", stall, 0);
    cyc();
    bus_ack = 0; no_req();
    #2;
    check("lb_ldv", ldata_valid, 1);
    check("lb_ldata", ldata, 32'hFFFFFF80);
    check("lb_ldrd", ld_rd, 5'd5);
    check("lb_req_off", bus_req, 0);
    cyc(); #2;
    check("lb_ldv_off", ldata_valid, 0);
    check("lb_hold", ldata, 32'hFFFFFF80);

    // lhu 0x202
    cyc();
    load(32'h202, 2'b01, 1, 5'd7);
    cyc();
    bus_ack = 1; bus_rdata = 32'hBEEF1234;
    #2;
    check("lhu_stall", stall, 0);
    cyc();
    bus_ack = 0; no_req();
    #2;
    check("lhu_ldata", ldata, 32'h0000BEEF);
    check("lhu_ldv", ldata_valid, 1);
    check("lhu_ldrd", ld_rd, 5'd7);

    // sh 0x202
    cyc();
    store(32'h202, 2'b10, 32'h0000ABCD);
    cyc();
    bus_ack = 1;
    #2;
    check("sh_be", bus_be, 4'b1100);
    check("sh_wdata", bus_wdata, 32'hABCDABCD);
    check("sh_we", bus_we, 1);
    check("sh_addr", bus_addr, 32'h200);
    cyc();
    bus_ack = 0; no_req();
    #2;
    check("sh_ldv", ldata_valid, 0);
    check("sh_req_off", bus_req, 0);
    check("sh_ldhold", ldata, 32'h0000BEEF);

    // lw misaligned at 0x105
    cyc();
    load(32'h105, 2'b00, 0, 5'd2);
    #2;
    check("mis_pulse", misalign, 1);
    check("mis_stall", stall, 0);
    cyc();
    no_req();
    #2;
    check("mis_off", misalign, 0);
    check("mis_req", bus_req, 0);

    // Timeout: no ack for 4 BUSY cycles
    cyc();
    load(32'h300, 2'b00, 0, 5'd9);
    for (int i = 0; i < 3; i++) begin
      cyc(); #2;
      check("to_stall", stall, 1);
      check("to_err_lo", bus_err, 0);
    end
    cyc(); #2;
    check("to_err", bus_err, 1);
    check("to_stall4", stall, 0);
    check("to_req4", bus_req, 1);
    cyc();
    no_req();
    #2;
    check("to_err_off", bus_err, 0);
    check("to_req_off", bus_req, 0);
    check("to_ldv", ldata_valid, 0);
    cyc(); #2;
    check("to_ldv2", ldata_valid, 0);
    check("to_idle", stall, 0);

    // Ack arriving in the timeout cycle wins
    cyc();
    load(32'h304, 2'b00, 0, 5'd10);
    for (int i = 0; i < 3; i++) cyc();
    cyc();
    bus_ack = 1; bus_rdata = 32'h12345678;
    #2;
    check("ack4_err", bus_err, 0);
    check("ack4_stall", stall, 0);
    cyc();
    bus_ack = 0; no_req();
    #2;
    check("ack4_ldv", ldata_valid, 1);
    check("ack4_ldata", ldata, 32'h12345678);
    check("ack4_ldrd", ld_rd, 5'd10);

    // Reset asserted in the 2nd BUSY cycle of a sw
    cyc();
    store(32'h40, 2'b01, 32'hDEADBEEF);
    cyc(); #2;
    check("sw_wdata", bus_wdata, 32'hDEADBEEF);
    check("sw_be", bus_be, 4'b1111);
    cyc();
    #1 reset = 0;
    #1;
    check("rb_req", bus_req, 0);
    check("rb_stall", stall, 0);
    check("rb_addr", bus_addr, 0);
    check("rb_wdata", bus_wdata, 0);
    check("rb_be", bus_be, 0);
    check("rb_we", bus_we, 0);
    check("rb_ldata", ldata, 0);
    check("rb_ldrd", ld_rd, 0);
    cyc();
    no_req(); reset = 1;
    cyc();
    bus_ack = 1; bus_rdata = 32'hCAFEF00D;
    #2;
    check("late_req", bus_req, 0);
    check("late_stall", stall, 0);
    cyc();
    bus_ack = 0;
    #2;
    check("late_ldv", ldata_valid, 0);
    check("late_ldata", ldata, 0);

    // Back-to-back sb with immediate acks
    for (int i = 0; i < 4; i++) begin
      cyc();
      store(32'(i), 2'b11, 32'h000000A5);
      bus_ack = 0;
      #2;
      check("sb_stall", stall, 1);
      cyc();
      bus_ack = 1;
      #2;
      check("sb_be", bus_be, sb_be[i]);
      check("sb_wdata", bus_wdata, 32'hA5A5A5A5);
      check("sb_stall_ack", stall, 0);
    end
    cyc();
    bus_ack = 0; no_req();
    #2;
    check("sb_req_off", bus_req, 0);
    check("sb_ldv", ldata_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
